gnr_attractor_detector: RTL and testbench

Run controller and attractor detector for the gene-regulatory-network simulator. It drives every node's `reset_nos`, `start_s0`, `start_s1` and `init_state` inputs, and consumes the concatenated node outputs as two state vectors: the tortoise copy `s0`, which advances every other `start_s0`, and the hare copy `s1`, which advances every `start_s1`. It runs Floyd cycle detection from a seeded initial state, then measures the attractor period and reports the attractor state, detection step count and period to the host.

---
 rtl/gnr_attractor_detector_if.sv | 34 +++
 rtl/gnr_attractor_detector.sv | 121 ++++++++++++
 tb/tb_gnr_attractor_detector.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gnr_attractor_detector_if.sv
// Host and node-array signals of the GRN attractor detector.
// The master side is the host plus node array; the slave side is the detector.
interface gnr_attractor_detector_if #(
    parameter int N  = 8,
    parameter int CW = 32
);
    logic          start;
    logic [N-1:0]  init_vec;
    logic [CW-1:0] max_steps;
    logic [N-1:0]  s0_vec;
    logic [N-1:0]  s1_vec;
    logic          reset_nos;
    logic [N-1:0]  init_state;
    logic          start_s0;
    logic          start_s1;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [N-1:0]  attractor;
    logic [CW-1:0] steps;
    logic [CW-1:0] period;

    modport master (
        output start, init_vec, max_steps, s0_vec, s1_vec,
        input  reset_nos, init_state, start_s0, start_s1,
               busy, done, timeout, attractor, steps, period
    );

    modport slave (
        input  start, init_vec, max_steps, s0_vec, s1_vec,
        output reset_nos, init_state, start_s0, start_s1,
               busy, done, timeout, attractor, steps, period
    );
endinterface

// File: rtl/gnr_attractor_detector.sv
// Run controller for the GRN simulator: Floyd cycle detection from a seed,
// then attractor period measurement. All outputs are registered.
//
// state  | meaning
// IDLE   | waiting for start, results held
// LOAD   | reset_nos pulse, nodes load the seed
// STEP   | dual strobe, hare and tortoise advance
// CHECK  | compare s0/s1 on even step counts, check step bound
// PSTEP  | hare-only strobe while measuring the period
// PCHECK | compare hare to captured attractor, check period bound
// DONE   | one-cycle done pulse
module gnr_attractor_detector #(
    parameter int N  = 8,
    parameter int CW = 32
) (
    input logic                     clk,
    input logic                     rst_n,
    gnr_attractor_detector_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, LOAD, STEP, CHECK, PSTEP, PCHECK, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  seed_q, attr_q;
    logic [CW-1:0] max_q, steps_q, period_q;
    logic          timeout_q;
    logic          reset_nos_d, start_s0_d, start_s1_d, busy_d, done_d;
    logic          reset_nos_q, start_s0_q, start_s1_q, busy_q, done_q;
    logic          hit, step_to, cyc_hit, per_to;

    // Tortoise lags at ceil(k/2) steps, so only even k can be a true meet.
    assign hit     = (state == CHECK) && !steps_q[0] && (bus.s0_vec == bus.s1_vec);
    assign step_to = (state == CHECK) && !hit && (steps_q >= max_q);
    assign cyc_hit = (state == PCHECK) && (bus.s1_vec == attr_q);
    assign per_to  = (state == PCHECK) && !cyc_hit && (period_q >= max_q);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD;
            LOAD:    state_nxt = STEP;
            STEP:    state_nxt = CHECK;
            CHECK:   state_nxt = hit ? PSTEP : (step_to ? DONE : STEP);
            PSTEP:   state_nxt = PCHECK;
            PCHECK:  state_nxt = (cyc_hit || per_to) ? DONE : PSTEP;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded from the next state so the registered strobes line up with it.
    always_comb begin
        reset_nos_d = (state_nxt == LOAD);
        start_s0_d  = (state_nxt == STEP);
        start_s1_d  = (state_nxt == STEP) || (state_nxt == PSTEP);
        busy_d      = (state_nxt != IDLE);
        done_d      = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reset_nos_q <= 1'b0;
            start_s0_q  <= 1'b0;
            start_s1_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            reset_nos_q <= reset_nos_d;
            start_s0_q  <= start_s0_d;
            start_s1_q  <= start_s1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seed_q    <= '0;
            max_q     <= '0;
            steps_q   <= '0;
            period_q  <= '0;
            attr_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                seed_q    <= bus.init_vec;
                max_q     <= bus.max_steps;
                steps_q   <= '0;
                period_q  <= '0;
                timeout_q <= 1'b0;
            end
            if (state_nxt == STEP)  steps_q  <= steps_q + CW'(1);
            if (state_nxt == PSTEP) period_q <= period_q + CW'(1);
            if (hit)                attr_q   <= bus.s0_vec;
            if (step_to)            timeout_q <= 1'b1;
            if (per_to) begin
                timeout_q <= 1'b1;
                period_q  <= '0;
            end
        end
    end

    assign bus.reset_nos  = reset_nos_q;
    assign bus.init_state = seed_q;
    assign bus.start_s0   = start_s0_q;
    assign bus.start_s1   = start_s1_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.attractor  = attr_q;
    assign bus.steps      = steps_q;
    assign bus.period     = period_q;

endmodule

// File: tb/tb_gnr_attractor_detector.sv
// Bench for gnr_attractor_detector: behavioural node array, directed runs,
// expected results queued at start and checked by a monitor on done.
module tb_gnr_attractor_detector;
    localparam int N  = 8;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gnr_attractor_detector_if #(.N(N), .CW(CW)) bus ();
    gnr_attractor_detector #(.N(N), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Node array: 0 = fixed point, 1 = all NOT, 2 = rotate ring on nodes 0..2
    // (nodes 3..7 hold their value, so the ring behaves as a 3-node network).
    int net_mode = 0;
    logic [N-1:0] t_q = '0;
    logic [N-1:0] h_q = '0;
    logic         pass_q = 1'b0;

    function automatic logic [N-1:0] nxt(input logic [N-1:0] s);
        case (net_mode)
            1:       return ~s;
            2:       return {s[7:3], s[1:0], s[2]};
            default: return s;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.reset_nos) begin
            t_q    <= bus.init_state;
            h_q    <= bus.init_state;
            pass_q <= 1'b0;
        end else begin
            if (bus.start_s0) begin
                if (!pass_q) t_q <= nxt(t_q);
                pass_q <= ~pass_q;
            end
            if (bus.start_s1) h_q <= nxt(h_q);
        end
    end
    assign bus.s0_vec = t_q;
    assign bus.s1_vec = h_q;

    int dual_cnt = 0;
    int s1_cnt = 0;
    always @(posedge clk) begin
        if (bus.reset_nos) begin
            dual_cnt <= 0;
            s1_cnt   <= 0;
        end else if (bus.start_s0 && bus.start_s1) dual_cnt <= dual_cnt + 1;
        else if (bus.start_s1)                      s1_cnt   <= s1_cnt + 1;
    end

    typedef struct {
        logic [N-1:0] attr;
        int           steps;
        int           period;
        logic         to;
        int           done_at;
    } exp_t;
    exp_t exp_q[$];

    bit chk_fall = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_fall) begin
                chk("busy_fall", bus.busy, 0);
                chk_fall = 1'b0;
            end
            if (bus.reset_nos) chk("strobe_overlap", {bus.start_s0, bus.start_s1}, 0);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.done_at);
                    chk("attractor", bus.attractor, e.attr);
                    chk("steps", bus.steps, e.steps);
                    chk("period", bus.period, e.period);
                    chk("timeout", bus.timeout, e.to);
                    chk("busy_at_done", bus.busy, 1);
                    chk("dual_strobes", dual_cnt, e.steps);
                    chk("s1_only_strobes", s1_cnt, e.period);
                end
                chk_fall = 1'b1;
            end
        end
    end

    task automatic run(input int mode, input logic [N-1:0] seed, input logic [CW-1:0] mx,
                       input logic [N-1:0] e_attr, input int e_steps, input int e_per,
                       input logic e_to, input int e_off, input bit dbl);
        int   t0;
        exp_t e;
        @(negedge clk);
        net_mode      = mode;
        bus.init_vec  = seed;
        bus.max_steps = mx;
        bus.start     = 1'b1;
        t0            = cyc;
        e.attr = e_attr; e.steps = e_steps; e.period = e_per; e.to = e_to;
        e.done_at = t0 + e_off;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        chk("load_reset_nos", bus.reset_nos, 1);
        chk("load_busy", bus.busy, 1);
        chk("load_init_state", bus.init_state, seed);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            bus.start = (dbl && cyc == t0 + 5);
        end
        bus.start = 1'b0;
        if (exp_q.size() != 0) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {bus.reset_nos, bus.start_s0, bus.start_s1, bus.busy,
                             bus.done, bus.timeout, bus.init_state, bus.attractor}, 0);
        chk({tag, "_steps"}, bus.steps, 0);
        chk({tag, "_period"}, bus.period, 0);
    endtask

    initial begin
        int t0;
        bus.start = 1'b0;
        bus.init_vec = '0;
        bus.max_steps = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 8'h00, 100, 8'h00, 2, 1, 1'b0, 8, 1'b0);
        run(1, 8'h0F, 100, 8'h0F, 4, 2, 1'b0, 14, 1'b0);
        run(2, 8'h01, 100, 8'h01, 6, 3, 1'b0, 20, 1'b0);
        // Timeouts leave the attractor from the previous run untouched.
        run(2, 8'h01, 3, 8'h01, 3, 0, 1'b1, 8, 1'b0);
        run(2, 8'h01, 0, 8'h01, 1, 0, 1'b1, 4, 1'b0);
        run(2, 8'h01, 100, 8'h01, 6, 3, 1'b0, 20, 1'b1);

        // Reset mid-run at T+6 of a ring run.
        @(negedge clk);
        net_mode = 2;
        bus.init_vec = 8'h01;
        bus.max_steps = 100;
        bus.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < t0 + 6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midrun_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_done_after_reset", bus.done, 0);
        run(2, 8'h01, 100, 8'h01, 6, 3, 1'b0, 20, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
